int_ctrl: RTL and testbench

Parametrised interrupt controller for the 8051 core. It replaces the per-source single-edge detectors with one block that serves N_SRC sources. Each source has its own edge or level trigger mode, pending flag and enable. Sources are arbitrated by a two-level priority (8051 IP semantics), the block tracks which levels are in service so ISRs can nest, and it presents a vector address to the core's fetch unit. The SFR block supplies the IE/IP/TCON-derived controls; the core supplies the acknowledge and RETI strobes.

---
 rtl/int_ctrl.sv | 100 ++++++++++
 tb/tb_int_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller for the 8051 core: per-source edge/level pending, two-level priority
// arbitration with in-service tracking for nesting, and registered vector presentation.
module int_ctrl #(
  parameter int unsigned N_SRC      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int unsigned VEC_STRIDE = 8,
  parameter int unsigned SRC_W      = $clog2(N_SRC)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ea,
  input  logic [N_SRC-1:0] i_en,
  input  logic [N_SRC-1:0] i_prio,
  input  logic [N_SRC-1:0] i_edge,
  input  logic [N_SRC-1:0] i_req,
  input  logic             i_ack,
  input  logic             i_reti,
  output logic             o_irq,
  output logic [15:0]      o_vec,
  output logic [SRC_W-1:0] o_src_id,
  output logic [N_SRC-1:0] o_pend,
  output logic [1:0]       o_active
);

  logic [N_SRC-1:0] req_q, pend_q, pend_d, rise, clr, pend_arb, elig;
  logic [1:0]       active_q, active_d;
  logic             lvl_q, lvl_d, irq_d, ack_ok;
  logic             hi_found, lo_found, pres_hi, pres_lo;
  logic [SRC_W-1:0] hi_idx, lo_idx, src_d;
  logic [15:0]      vec_d;

  assign ack_ok = i_ack & o_irq;
  assign rise   = i_req & ~req_q;

  always_comb begin
    clr      = '0;
    pend_d   = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      clr[i] = ack_ok & i_edge[i] & (o_src_id == SRC_W'(i));
      // A new edge in the same cycle as the clear keeps the flag set.
      pend_d[i] = i_edge[i] ? ((pend_q[i] & ~clr[i]) | rise[i]) : i_req[i];
    end

    active_d = active_q;
    if (i_reti) begin
      if (active_q[1]) active_d[1] = 1'b0;
      else             active_d[0] = 1'b0;
    end
    if (ack_ok) active_d[lvl_q] = 1'b1;

    // Arbitrate on the post-ack state so an accepted source drops on the very next cycle.
    pend_arb = pend_q & ~clr;
    elig     = pend_arb & i_en & {N_SRC{i_ea}};
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!hi_found && elig[i] && i_prio[i]) begin
        hi_found = 1'b1;
        hi_idx   = SRC_W'(i);
      end
      if (!lo_found && elig[i] && !i_prio[i]) begin
        lo_found = 1'b1;
        lo_idx   = SRC_W'(i);
      end
    end

    pres_hi = hi_found & ~active_d[1];
    pres_lo = lo_found & (active_d == 2'b00) & ~pres_hi;
    irq_d   = pres_hi | pres_lo;
    lvl_d   = pres_hi;
    src_d   = pres_hi ? hi_idx : (pres_lo ? lo_idx : '0);
    vec_d   = VEC_BASE + 16'(VEC_STRIDE * 32'(src_d));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q    <= '0;
      pend_q   <= '0;
      active_q <= 2'b00;
      lvl_q    <= 1'b0;
      o_irq    <= 1'b0;
      o_src_id <= '0;
      o_vec    <= VEC_BASE;
    end else begin
      req_q    <= i_req;
      pend_q   <= pend_d;
      active_q <= active_d;
      lvl_q    <= lvl_d;
      o_irq    <= irq_d;
      o_src_id <= src_d;
      o_vec    <= vec_d;
    end
  end

  assign o_pend   = pend_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scenario bench for int_ctrl: expected vectors queued at stimulus, compared when presented.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ea;
  logic [4:0]  en, prio, edge_mode, req;
  logic        ack, reti;
  logic        irq;
  logic [15:0] vec;
  logic [2:0]  src_id;
  logic [4:0]  pend;
  logic [1:0]  active;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t exp_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  int_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_ea(ea), .i_en(en), .i_prio(prio), .i_edge(edge_mode),
    .i_req(req), .i_ack(ack), .i_reti(reti), .o_irq(irq), .o_vec(vec), .o_src_id(src_id),
    .o_pend(pend), .o_active(active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] id);
    exp_t e;
    e.id  = id;
    e.vec = 16'h0003 + 16'(8 * 32'(id));
    sb.push_back(e);
  endtask

  task automatic pulse_req(input int idx);
    req[idx] = 1'b1;
    tick();
    req[idx] = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if ({irq, vec, src_id, pend, active} !== {1'b0, 16'h0003, 3'd0, 5'd0, 2'b00}) begin
      $display("FAIL reset_state: got irq=%b vec=%h id=%0d pend=%b act=%b want 0 0003 0 0 00",
               irq, vec, src_id, pend, active);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_single_edge();
    push_exp(3'd1);
    pulse_req(1);
    if ({pend, irq} !== {5'b00010, 1'b0}) begin
      $display("FAIL single_pend: got pend=%b irq=%b want 00010 0", pend, irq);
      n_fail++;
    end
    n_tests++;
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL single_present: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    if ({pend, active, irq} !== {5'b00000, 2'b01, 1'b0}) begin
      $display("FAIL single_ack: got pend=%b act=%b irq=%b want 00000 01 0", pend, active, irq);
      n_fail++;
    end
    n_tests++;
    pulse_reti();
    if (active !== 2'b00) begin
      $display("FAIL single_reti: got act=%b want 00", active);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_simultaneous();
    push_exp(3'd1);
    push_exp(3'd3);
    req = 5'b01010;
    tick();
    req = 5'b00000;
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL simul_first: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    if ({irq, active, pend} !== {1'b0, 2'b01, 5'b01000}) begin
      $display("FAIL simul_blocked: got irq=%b act=%b pend=%b want 0 01 01000", irq, active, pend);
      n_fail++;
    end
    n_tests++;
    pulse_reti();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL simul_second: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    pulse_reti();
  endtask

  task automatic test_preempt();
    push_exp(3'd0);
    pulse_req(0);
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL preempt_low: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    prio[2] = 1'b1;
    push_exp(3'd2);
    pulse_req(2);
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id, active} !== {1'b1, exp_e.vec, exp_e.id, 2'b01}) begin
      $display("FAIL preempt_high: got irq=%b vec=%h id=%0d act=%b want 1 %h %0d 01",
               irq, vec, src_id, active, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    if ({active, irq} !== {2'b11, 1'b0}) begin
      $display("FAIL preempt_nest: got act=%b irq=%b want 11 0", active, irq);
      n_fail++;
    end
    n_tests++;
    pulse_reti();
    if (active !== 2'b01) begin
      $display("FAIL preempt_reti1: got act=%b want 01", active);
      n_fail++;
    end
    n_tests++;
    pulse_reti();
    if ({active, irq} !== {2'b00, 1'b0}) begin
      $display("FAIL preempt_reti2: got act=%b irq=%b want 00 0", active, irq);
      n_fail++;
    end
    n_tests++;
    prio[2] = 1'b0;
  endtask

  task automatic test_level();
    edge_mode[0] = 1'b0;
    req[0]       = 1'b1;
    push_exp(3'd0);
    tick();
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL level_present: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    if ({pend[0], active, irq} !== {1'b1, 2'b01, 1'b0}) begin
      $display("FAIL level_ack: got pend0=%b act=%b irq=%b want 1 01 0", pend[0], active, irq);
      n_fail++;
    end
    n_tests++;
    push_exp(3'd0);
    pulse_reti();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id, active} !== {1'b1, exp_e.vec, exp_e.id, 2'b00}) begin
      $display("FAIL level_represent: got irq=%b vec=%h id=%0d act=%b want 1 %h %0d 00",
               irq, vec, src_id, active, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    req[0] = 1'b0;
    tick();
    if (pend[0] !== 1'b0) begin
      $display("FAIL level_drop: got pend0=%b want 0", pend[0]);
      n_fail++;
    end
    n_tests++;
    tick();
    if (irq !== 1'b0) begin
      $display("FAIL level_irq_drop: got irq=%b want 0", irq);
      n_fail++;
    end
    n_tests++;
    edge_mode[0] = 1'b1;
  endtask

  task automatic test_enable_reset();
    en[4] = 1'b0;
    pulse_req(4);
    tick();
    if ({irq, pend} !== {1'b0, 5'b10000}) begin
      $display("FAIL mask_hold: got irq=%b pend=%b want 0 10000", irq, pend);
      n_fail++;
    end
    n_tests++;
    en[4] = 1'b1;
    push_exp(3'd4);
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL unmask_present: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    pulse_ack();
    prio[2] = 1'b1;
    pulse_req(2);
    tick();
    pulse_ack();
    pulse_req(3);
    if ({active, pend} !== {2'b11, 5'b01000}) begin
      $display("FAIL pre_reset: got act=%b pend=%b want 11 01000", active, pend);
      n_fail++;
    end
    n_tests++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if ({irq, vec, src_id, pend, active} !== {1'b0, 16'h0003, 3'd0, 5'd0, 2'b00}) begin
      $display("FAIL mid_isr_reset: got irq=%b vec=%h id=%0d pend=%b act=%b want 0 0003 0 0 00",
               irq, vec, src_id, pend, active);
      n_fail++;
    end
    n_tests++;
    prio[2] = 1'b0;
  endtask

  task automatic test_ack_idle();
    pulse_ack();
    if ({irq, pend, active} !== {1'b0, 5'd0, 2'b00}) begin
      $display("FAIL ack_idle: got irq=%b pend=%b act=%b want 0 0 00", irq, pend, active);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_ack_reti();
    push_exp(3'd1);
    pulse_req(1);
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL ackreti_present: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    ack  = 1'b1;
    reti = 1'b1;
    tick();
    ack  = 1'b0;
    reti = 1'b0;
    if ({active, pend} !== {2'b01, 5'd0}) begin
      $display("FAIL ackreti_low: got act=%b pend=%b want 01 00000", active, pend);
      n_fail++;
    end
    n_tests++;
    // RETI of the low ISR coinciding with acceptance of a high source.
    prio[2] = 1'b1;
    push_exp(3'd2);
    pulse_req(2);
    tick();
    exp_e = sb.pop_front();
    if ({irq, vec, src_id} !== {1'b1, exp_e.vec, exp_e.id}) begin
      $display("FAIL ackreti_hi_present: got irq=%b vec=%h id=%0d want 1 %h %0d",
               irq, vec, src_id, exp_e.vec, exp_e.id);
      n_fail++;
    end
    n_tests++;
    ack  = 1'b1;
    reti = 1'b1;
    tick();
    ack  = 1'b0;
    reti = 1'b0;
    if ({active, pend, irq} !== {2'b10, 5'd0, 1'b0}) begin
      $display("FAIL ackreti_high: got act=%b pend=%b irq=%b want 10 00000 0", active, pend, irq);
      n_fail++;
    end
    n_tests++;
    pulse_reti();
    if (active !== 2'b00) begin
      $display("FAIL ackreti_final: got act=%b want 00", active);
      n_fail++;
    end
    n_tests++;
    prio[2] = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ea        = 1'b1;
    en        = 5'b11111;
    prio      = 5'b00000;
    edge_mode = 5'b11111;
    req       = 5'b00000;
    ack       = 1'b0;
    reti      = 1'b0;
    tick();
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_preempt();
    test_level();
    test_enable_reset();
    test_ack_idle();
    test_ack_reti();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      n_fail++;
    end
    n_tests++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
